// File: rtl/binary_search_engine_pkg.sv
// Shared types and helpers for the sorted-array binary search engine.
package bsearch_pkg;

    // Search flavour, latched together with the target on start.
    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_LOWER = 2'b01,
        MODE_UPPER = 2'b10
    } search_mode_t;

    // Controller states: one probe is CHECK -> ISSUE -> COMPARE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } bsearch_state_t;

    // Operands are widened to this width (sign- or zero-extended by the caller)
    // so one comparator serves every DATA_W below it.
    localparam int CMP_W = 64;

    // Less-than in either two's-complement or unsigned interpretation.
    function automatic logic compare_lt(
        input logic [CMP_W-1:0] a,
        input logic [CMP_W-1:0] b,
        input logic             signed_en
    );
        if (signed_en) begin
            return $signed(a) < $signed(b);
        end
        return a < b;
    endfunction

endpackage

// File: rtl/binary_search_engine.sv
// Binary search over an external synchronous-read memory of DEPTH sorted words.
// Half-open interval [lo, hi); result index = lo on loop exit.
module binary_search_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  search_mode_t      mode,
    input  logic [DATA_W-1:0] target,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W:0]   index,
    output logic [ADDR_W:0]   iters
);

    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic            SIGNED_EN = (SIGNED != 0);

    // Widen a data word to the comparator width honouring signedness.
    function automatic logic [CMP_W-1:0] widen(input logic [DATA_W-1:0] v);
        logic [CMP_W-1:0] r;
        r = '0;
        r[DATA_W-1:0] = v;
        if (SIGNED_EN && v[DATA_W-1]) begin
            r[CMP_W-1:DATA_W] = '1;
        end
        return r;
    endfunction

    bsearch_state_t    state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [ADDR_W:0]   lo_q, lo_d;
    logic [ADDR_W:0]   hi_q, hi_d;
    logic [ADDR_W:0]   mid_q, mid_d;
    logic              eq_hit_q, eq_hit_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [ADDR_W:0]   index_q, index_d;
    logic [ADDR_W:0]   iters_q, iters_d;

    logic              x_lt_t;
    logic              t_lt_x;
    logic              x_eq_t;
    logic [ADDR_W:0]   mid_next;

    // Probe comparisons of the returned word against the latched target.
    always_comb begin
        x_lt_t   = compare_lt(widen(mem_rdata), widen(target_q), SIGNED_EN);
        t_lt_x   = compare_lt(widen(target_q), widen(mem_rdata), SIGNED_EN);
        x_eq_t   = (mem_rdata == target_q);
        mid_next = lo_q + ((hi_q - lo_q) >> 1);
    end

    // Next-state and next-output computation for the search controller.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        target_d   = target_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        eq_hit_d   = eq_hit_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        found_d    = found_q;
        index_d    = index_q;
        iters_d    = iters_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    target_d = target;
                    lo_d     = '0;
                    hi_d     = DEPTH_L;
                    eq_hit_d = 1'b0;
                    iters_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (lo_q < hi_q) begin
                    // Address and strobe are registered here so they are
                    // stable for the whole ISSUE cycle.
                    mid_d      = mid_next;
                    mem_en_d   = 1'b1;
                    mem_addr_d = mid_next[ADDR_W-1:0];
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ISSUE: begin
                iters_d = iters_q + 1'b1;
                state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (mode_q == MODE_UPPER) begin
                    if (!t_lt_x) begin
                        lo_d = mid_q + 1'b1;
                    end else begin
                        hi_d = mid_q;
                    end
                end else begin
                    // EXACT, LOWER and the reserved encoding share this rule;
                    // eq_hit tracks whether the current hi points at a match.
                    if (x_lt_t) begin
                        lo_d = mid_q + 1'b1;
                    end else begin
                        hi_d     = mid_q;
                        eq_hit_d = x_eq_t;
                    end
                end
                state_d = ST_CHECK;
            end
            ST_DONE: begin
                index_d = lo_q;
                if ((mode_q == MODE_LOWER) || (mode_q == MODE_UPPER)) begin
                    found_d = (lo_q < DEPTH_L);
                end else begin
                    found_d = (lo_q < DEPTH_L) && eq_hit_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; active-low synchronous reset aborts any search.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_EXACT;
            target_q   <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            mid_q      <= '0;
            eq_hit_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            index_q    <= '0;
            iters_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            eq_hit_q   <= eq_hit_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            index_q    <= index_d;
            iters_q    <= iters_d;
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign index    = index_q;
    assign iters    = iters_q;

endmodule

// File: tb/tb_binary_search_engine.sv
// Directed bench: three engines (unsigned/16, signed/16, unsigned/1) each behind
// a one-cycle-latency memory model.
module tb_binary_search_engine;
    import bsearch_pkg::*;

    logic         clk;
    logic         rst;
    search_mode_t mode;
    logic [7:0]   target;
    logic         start_u, start_s, start_1;

    logic       en_u, busy_u, done_u, found_u;
    logic [3:0] addr_u;
    logic [7:0] rdata_u;
    logic [4:0] index_u, iters_u;

    logic       en_s, busy_s, done_s, found_s;
    logic [3:0] addr_s;
    logic [7:0] rdata_s;
    logic [4:0] index_s, iters_s;

    logic       en_1, busy_1, done_1, found_1;
    logic [0:0] addr_1;
    logic [7:0] rdata_1;
    logic [1:0] index_1, iters_1;

    logic [7:0] mem_u [16];
    logic [7:0] mem_s [16];
    logic [7:0] mem_1 [2];

    int tests = 0;
    int fails = 0;
    int done_cnt_u = 0;
    int sel = 0;

    logic        cur_done, cur_busy;
    logic [31:0] cur_index, cur_found, cur_iters;

    binary_search_engine #(.DATA_W(8), .DEPTH(16), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .mode(mode), .target(target),
        .mem_en(en_u), .mem_addr(addr_u), .mem_rdata(rdata_u),
        .busy(busy_u), .done(done_u), .found(found_u), .index(index_u), .iters(iters_u)
    );

    binary_search_engine #(.DATA_W(8), .DEPTH(16), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .mode(mode), .target(target),
        .mem_en(en_s), .mem_addr(addr_s), .mem_rdata(rdata_s),
        .busy(busy_s), .done(done_s), .found(found_s), .index(index_s), .iters(iters_s)
    );

    binary_search_engine #(.DATA_W(8), .DEPTH(1), .SIGNED(0)) dut_1 (
        .clk(clk), .rst(rst), .start(start_1), .mode(mode), .target(target),
        .mem_en(en_1), .mem_addr(addr_1), .mem_rdata(rdata_1),
        .busy(busy_1), .done(done_1), .found(found_1), .index(index_1), .iters(iters_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (en_u) rdata_u <= mem_u[addr_u];
        if (en_s) rdata_s <= mem_s[addr_s];
        if (en_1) rdata_1 <= mem_1[addr_1];
    end

    always @(negedge clk) begin
        if (done_u) done_cnt_u <= done_cnt_u + 1;
    end

    // Route the selected engine's outputs to common names for the run task.
    always_comb begin
        cur_done  = 1'b0;
        cur_busy  = 1'b0;
        cur_index = '0;
        cur_found = '0;
        cur_iters = '0;
        case (sel)
            0: begin
                cur_done = done_u; cur_busy = busy_u;
                cur_index = 32'(index_u); cur_found = 32'(found_u); cur_iters = 32'(iters_u);
            end
            1: begin
                cur_done = done_s; cur_busy = busy_s;
                cur_index = 32'(index_s); cur_found = 32'(found_s); cur_iters = 32'(iters_s);
            end
            default: begin
                cur_done = done_1; cur_busy = busy_1;
                cur_index = 32'(index_1); cur_found = 32'(found_1); cur_iters = 32'(iters_1);
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One search on engine `which`; checks busy timing, done latency and results.
    task automatic run(input string tag, input int which, input logic [1:0] m, input logic [7:0] t,
                       input int exp_idx, input int exp_found, input int exp_iters);
        int   cyc;
        logic seen;
        sel = which;
        @(negedge clk);
        mode   = search_mode_t'(m);
        target = t;
        start_u = (which == 0);
        start_s = (which == 1);
        start_1 = (which == 2);
        @(posedge clk);
        #1;
        start_u = 1'b0;
        start_s = 1'b0;
        start_1 = 1'b0;
        check({tag, "_busy_rise"}, 32'(cur_busy), 1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cur_done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 1);
        check({tag, "_latency"}, 32'(cyc), 32'(3 * exp_iters + 2));
        check({tag, "_busy_fall"}, 32'(cur_busy), 0);
        check({tag, "_index"}, cur_index, 32'(exp_idx));
        check({tag, "_found"}, cur_found, 32'(exp_found));
        check({tag, "_iters"}, cur_iters, 32'(exp_iters));
        $display("[TB] %s: index=%0d found=%0d iters=%0d cycles=%0d", tag, cur_index, cur_found, cur_iters, cyc);
    endtask

    initial begin
        int cnt0;
        int cyc;
        rst = 1'b0;
        start_u = 1'b0;
        start_s = 1'b0;
        start_1 = 1'b0;
        mode = MODE_EXACT;
        target = 8'd0;
        for (int i = 0; i < 16; i++) begin
            mem_u[i] = 8'(2 * i);
            mem_s[i] = 8'(i - 8);
        end
        mem_1[0] = 8'd5;
        mem_1[1] = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy_u), 0);
        check("rst_done", 32'(done_u), 0);
        check("rst_found", 32'(found_u), 0);
        check("rst_index", 32'(index_u), 0);
        check("rst_iters", 32'(iters_u), 0);
        check("rst_mem_en", 32'(en_u), 0);
        check("rst_mem_addr", 32'(addr_u), 0);
        $display("[TB] reset values checked");
        @(negedge clk);
        rst = 1'b1;

        // Memory A: mem[i] = 2*i
        run("A_exact_14", 0, 2'b00, 8'd14, 7, 1, 4);
        run("A_exact_15", 0, 2'b00, 8'd15, 8, 0, 4);
        run("A_lower_31", 0, 2'b01, 8'd31, 16, 0, 4);
        run("A_lower_0", 0, 2'b01, 8'd0, 0, 1, 5);
        run("A_resv_14", 0, 2'b11, 8'd14, 7, 1, 4);

        // Results hold between searches.
        repeat (5) @(posedge clk);
        #1;
        check("hold_index", 32'(index_u), 7);
        check("hold_found", 32'(found_u), 1);
        check("hold_iters", 32'(iters_u), 4);
        $display("[TB] hold: index=%0d found=%0d iters=%0d", index_u, found_u, iters_u);

        // Memory B: 1,3,3,3,5,7,...,27
        mem_u[0] = 8'd1; mem_u[1] = 8'd3; mem_u[2] = 8'd3; mem_u[3] = 8'd3;
        for (int i = 4; i < 16; i++) mem_u[i] = 8'(2 * i - 3);
        run("B_exact_3", 0, 2'b00, 8'd3, 1, 1, 5);
        run("B_upper_3", 0, 2'b10, 8'd3, 4, 1, 4);
        run("B_upper_255", 0, 2'b10, 8'd255, 16, 0, 4);

        // mem[i] = i-8 in both signednesses
        run("S_lower_m3", 1, 2'b01, 8'hFD, 5, 1, 4);
        for (int i = 0; i < 16; i++) mem_u[i] = 8'(i - 8);
        run("U_lower_FD", 0, 2'b01, 8'hFD, 16, 0, 4);

        // DEPTH = 1: single probe
        run("D1_exact_5", 2, 2'b00, 8'd5, 0, 1, 1);
        run("D1_exact_9", 2, 2'b00, 8'd9, 1, 0, 1);

        // start pulsed while busy is ignored
        cnt0 = done_cnt_u;
        @(negedge clk);
        mode = MODE_LOWER; target = 8'hFD; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        repeat (4) @(negedge clk);
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_start_dones", 32'(done_cnt_u - cnt0), 1);
        check("busy_start_index", 32'(index_u), 16);
        $display("[TB] start while busy: dones=%0d index=%0d", done_cnt_u - cnt0, index_u);

        // mode/target changes after latching have no effect
        for (int i = 0; i < 16; i++) mem_u[i] = 8'(2 * i);
        sel = 0;
        @(negedge clk);
        mode = MODE_EXACT; target = 8'd14; start_u = 1'b1;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mode = MODE_UPPER; target = 8'd30;
        cyc = 0;
        while (!done_u && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("chg_done_seen", 32'(done_u), 1);
        check("chg_index", 32'(index_u), 7);
        check("chg_found", 32'(found_u), 1);
        $display("[TB] target change: index=%0d found=%0d", index_u, found_u);

        // Reset during the 4th cycle of a search
        @(negedge clk);
        mode = MODE_EXACT; target = 8'd14; start_u = 1'b1;
        @(posedge clk);
        #1;
        start_u = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy_u), 0);
        check("abort_done", 32'(done_u), 0);
        check("abort_found", 32'(found_u), 0);
        check("abort_index", 32'(index_u), 0);
        check("abort_iters", 32'(iters_u), 0);
        check("abort_mem_en", 32'(en_u), 0);
        check("abort_mem_addr", 32'(addr_u), 0);
        @(negedge clk);
        rst = 1'b1;
        cnt0 = done_cnt_u;
        repeat (30) @(negedge clk);
        check("abort_no_done", 32'(done_cnt_u - cnt0), 0);
        $display("[TB] reset abort: extra dones=%0d", done_cnt_u - cnt0);
        run("post_rst_exact_15", 0, 2'b00, 8'd15, 8, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/binary_search_engine.md
# binary_search_engine

Parametrised sorted-array search engine: given a target it binary-searches an externally attached synchronous-read memory of `DEPTH` sorted words and returns an index plus found flag. Three modes are supported: exact match (first occurrence), lower bound and upper bound. Signedness is selectable. It uses a start/busy/done handshake and is the search core for the sorted-table lookups in the design.

## Interface
- `DATA_W`, default 8: width of each memory word and of the target.
- `DEPTH`, default 16: number of sorted words. Must be ≥ 1.
- `ADDR_W`, default `$clog2(DEPTH)` (min 1): memory address width.
- `SIGNED`, default 0: 1 means compares are two's-complement, 0 means unsigned.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, **synchronous, active-low** (block is reset when `rst`=0 at a clock edge).
- `start`  in  1  request; sampled only in IDLE.
- `mode`  in  2  `search_mode_t`; latched with `start`.
- `target`  in  DATA_W  search key; latched with `start`.
- `mem_en`  out  1  read strobe to the memory.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rdata`  in  DATA_W  read data; valid the cycle after `mem_en`.
- `busy`  out  1  search in progress.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `found`  out  1  see modes.
- `index`  out  ADDR_W+1  result index; range 0..DEPTH.
- `iters`  out  ADDR_W+1  number of memory probes used.

## Operation
- Internal `lo`, `hi`, `mid` are ADDR_W+1 bits wide, using a half-open interval [lo, hi).
- `mid = lo + ((hi - lo) >> 1)`. No overflow is possible at ADDR_W+1 bits.
- Probe rule for `x = mem[mid]`:
  - EXACT and LOWER: if `x < target` then `lo = mid+1`; else `hi = mid` and `eq_hit = (x == target)`.
  - UPPER: if `x <= target` then `lo = mid+1`; else `hi = mid`.
- Result is `index = lo` (equal to `hi`) at loop exit.
- `found` by mode:
  - EXACT: `found = (index < DEPTH) && eq_hit`. `eq_hit` is cleared at start, so with duplicates `index` is the first occurrence. On a miss, `index` is the insertion point.
  - LOWER: `index` is the first element ≥ target; `found = index < DEPTH`.
  - UPPER: `index` is the first element > target; `found = index < DEPTH`.
  - Mode 2'b11 is reserved and behaves as EXACT.
- `iters` is at most ⌈log2(DEPTH+1)⌉.
- FSM states:
  - IDLE: on `start`, latch `mode` and `target`; set `lo=0`, `hi=DEPTH`; clear `eq_hit` and `iters`; go to CHECK.
  - CHECK: if `lo < hi`, register `mid` and go to ISSUE; else go to DONE.
  - ISSUE: `mem_en=1`, `mem_addr=mid[ADDR_W-1:0]`; `iters++`; go to COMPARE.
  - COMPARE: apply the probe rule using `mem_rdata`; go to CHECK.
  - DONE: register `index` and `found`; `done=1`; go to IDLE.
- Boundary behaviour:
  - `start` while busy is ignored.
  - `start` held high re-triggers a search on every return to IDLE.
  - `mode`/`target` changes after latching have no effect.
  - `index`, `found`, `iters` hold their values until the next DONE.
  - Reset mid-search aborts immediately with no `done` pulse.
  - For DEPTH=1 the search does exactly one probe.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `found`=0, `index`=0, `iters`=0, `mem_en`=0, `mem_addr`=0.
- `busy` rises the cycle after `start` is sampled and falls in the DONE cycle.
- For k probes, `done` is high exactly 3k+2 cycles after the edge that samples `start`.
- Next `start` is accepted in the cycle after DONE, giving a minimum period of 3k+3 cycles.
- Memory read latency is exactly 1 cycle. `mem_addr` is registered and stable for the whole ISSUE cycle.

## Structure
- `bsearch_pkg` holds:
  - `typedef enum logic [1:0] search_mode_t {MODE_EXACT=2'b00, MODE_LOWER=2'b01, MODE_UPPER=2'b10}`;
  - the FSM state enum `bsearch_state_t`;
  - a `compare_lt(a, b, signed_en)` function.
- No sub-module in the datapath. The bench instantiates the existing `memory` block behind `mem_*` and preloads the sorted contents.

## Test plan
Memory A is DEPTH=16 with `mem[i]=2*i` (values 0..30). Memory B is `{1,3,3,3,5,7,...}`.
- EXACT, target 14 on A -> `index`=7, `found`=1, `iters`≤5, `done` exactly 3·`iters`+2 cycles after start.
- EXACT, target 15 on A -> `index`=8, `found`=0. LOWER, target 31 -> `index`=16, `found`=0. LOWER, target 0 -> `index`=0, `found`=1.
- Memory B: EXACT, target 3 -> `index`=1, `found`=1. UPPER, target 3 -> `index`=4, `found`=1. UPPER, target 255 -> `index`=16, `found`=0.
- SIGNED=1, DEPTH=16, `mem[i]=i-8`, LOWER, target -3 (8'hFD) -> `index`=5, `found`=1. Same setup with SIGNED=0 -> `index`=16.
- `start` pulsed again while busy -> ignored, exactly one `done`. Change `target` mid-search -> result unchanged.
- `rst`=0 during the 4th cycle of a search -> all outputs return to reset values next edge, no `done`. Next search completes correctly.
